alu_pipe: RTL and testbench

Parametrised, registered execute-stage ALU with full NZCV status generation, valid/ready handshakes on both sides, and an optional iterative multiplier. It sits between the ID/EX pipeline register and the EX/MEM register. It replaces the purely combinational ALU with a block that can stall the pipeline for multi-cycle operations and absorb back-pressure from the memory stage.

---
 rtl/alu_pipe.sv | 188 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with NZCV status and valid/ready handshakes on both sides.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MUL command, busy, IDLE/MUL FSM).
module alu_pipe #(
    parameter int WIDTH     = 32,
    parameter int MUL_CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    if (WIDTH < 4 || (1 << MUL_CNT_W) <= WIDTH) begin : g_bad_params
        $error("alu_pipe: WIDTH must be >= 4 and 2**MUL_CNT_W must exceed WIDTH");
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_status;

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;
    logic             out_valid_q, out_valid_d;

    // Single-cycle datapath; cmd[0] selects the carry flavour (ADC/SBC) of ADD/SUB.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sum     = '0;
        alu_res = '0;
        alu_c   = carry_in;
        alu_v   = 1'b0;
        case (cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum     = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, cmd[0] & carry_in};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (val1[WIDTH-1] == val2[WIDTH-1]) && (alu_res[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum     = {1'b0, val1} + {1'b0, ~val2} + {{WIDTH{1'b0}}, cmd[0] ? carry_in : 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (val1[WIDTH-1] != val2[WIDTH-1]) && (alu_res[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_AND: alu_res = val1 & val2;
            CMD_ORR: alu_res = val1 | val2;
            CMD_EOR: alu_res = val1 ^ val2;
            default: alu_res = '0;
        endcase
        alu_status = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0]           CMD_MUL  = 4'b1010;
    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 mcin_q, mcin_d;
    logic [WIDTH-1:0]     acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign busy     = (state_q == S_MUL);

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mcin_d      = mcin_q;
        result_d    = result_q;
        status_d    = status_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    if (cmd == CMD_MUL) begin
                        mcand_d  = val1;
                        mplier_d = val2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mcin_d   = carry_in;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        status_d    = alu_status;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    result_d    = acc_next;
                    status_d    = {acc_next[WIDTH-1], acc_next == '0, mcin_q, 1'b0};
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcin_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mcin_q   <= mcin_d;
        end
    end
`else
    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign busy     = 1'b0;

    always_comb begin
        result_d    = result_q;
        status_d    = status_q;
        out_valid_d = out_valid_q && !out_ready;
        if (in_valid && in_ready) begin
            result_d    = alu_res;
            status_d    = alu_status;
            out_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            result_q    <= result_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign status    = status_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32); MUL scenarios run when ALU_MUL_EN is defined.
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   cmd = 4'b0000;
    logic [W-1:0] val1 = '0;
    logic [W-1:0] val2 = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [3:0]   status;
    logic         busy;

    int checks = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(W), .MUL_CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .val1      (val1),
        .val2      (val2),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] r;
        logic [3:0]   s;
    } vec_t;

    task automatic drive(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        in_valid = 1'b1;
        cmd      = c;
        val1     = a;
        val2     = b;
        carry_in = ci;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 0 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (result !== '0 || status !== 4'b0000) begin
            failures++;
            $display("FAIL reset_data: result=%h status=%b, want 0 0000", result, status);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_single_cycle();
        vec_t v [11];
        v[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001};
        v[1]  = '{4'b0100, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 4'b0110};
        v[2]  = '{4'b0101, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000};
        v[3]  = '{4'b0011, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 4'b0110};
        v[4]  = '{4'b1001, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b1010};
        v[5]  = '{4'b0001, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0100};
        v[6]  = '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b1000};
        v[7]  = '{4'b0111, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, 32'h0F0F_00F0, 4'b0000};
        v[8]  = '{4'b1000, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'h0000_0000, 4'b0110};
        v[9]  = '{4'b1111, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h0000_0000, 4'b0110};
        v[10] = '{4'b0100, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0011};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(v[i].c, v[i].a, v[i].b, v[i].ci);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_ready: in_ready=%b, want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== v[i].r || status !== v[i].s) begin
                failures++;
                $display("FAIL vec%0d_cmd%b: out_valid=%b result=%h status=%b, want 1 %h %b",
                         i, v[i].c, out_valid, result, status, v[i].r, v[i].s);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_valid: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(4'b0010, W'(i), W'(i), 1'b0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== W'(2 * i)) begin
                failures++;
                $display("FAIL stream%0d: out_valid=%b result=%h, want 1 %h", i, out_valid, result, W'(2 * i));
            end
        end
        out_ready = 1'b0;
        drive(4'b0010, 32'd10, 32'd10, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd8) begin
                failures++;
                $display("FAIL stall%0d: in_ready=%b out_valid=%b result=%h, want 0 1 8", i, in_ready, out_valid, result);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: in_ready=%b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd20) begin
            failures++;
            $display("FAIL after_stall: out_valid=%b result=%h, want 1 14", out_valid, result);
        end
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [W-1:0] ma [2];
        logic [W-1:0] mb [2];
        logic [W-1:0] mr [2];
        logic [3:0]   ms [2];
        int           lat;
        logic         bad;
        ma[0] = 32'h0001_0000; mb[0] = 32'h0001_0000; mr[0] = 32'h0; ms[0] = 4'b0100;
        ma[1] = 32'd7;         mb[1] = 32'd6;         mr[1] = 32'd42; ms[1] = 4'b0000;
        out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            drive(4'b1010, ma[t], mb[t], 1'b0);
            tick();
            in_valid = 1'b0;
            lat = 0;
            bad = 1'b0;
            while (out_valid !== 1'b1 && lat < 40) begin
                if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
                tick();
                lat++;
            end
            checks++;
            if (lat != W || bad) begin
                failures++;
                $display("FAIL mul%0d_timing: latency=%0d busy_ok=%b, want %0d 1", t, lat, !bad, W);
            end
            checks++;
            if (result !== mr[t] || status !== ms[t] || busy !== 1'b0) begin
                failures++;
                $display("FAIL mul%0d_result: result=%h status=%b busy=%b, want %h %b 0",
                         t, result, status, busy, mr[t], ms[t]);
            end
            tick();
        end
    endtask

    task automatic test_mul_reset_abort();
        logic seen;
        drive(4'b1010, 32'd7, 32'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || status !== 4'b0000 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mul_abort: busy=%b out_valid=%b status=%b in_ready=%b, want 0 0 0000 0",
                     busy, out_valid, status, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL mul_abort_quiet: out_valid/busy=1 seen, want 0");
        end
        drive(4'b0010, 32'd2, 32'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5 || status !== 4'b0000) begin
            failures++;
            $display("FAIL add_after_abort: out_valid=%b result=%h status=%b, want 1 5 0000", out_valid, result, status);
        end
        tick();
    endtask
`else
    task automatic test_mul_disabled();
        drive(4'b1010, 32'd7, 32'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== '0 || status !== 4'b0110 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mul_disabled: out_valid=%b result=%h status=%b busy=%b, want 1 0 0110 0",
                     out_valid, result, status, busy);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        drive(4'b0010, 32'd1, 32'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: out_valid=%b result=%h in_ready=%b, want 0 0 0", out_valid, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        drive(4'b0010, 32'd2, 32'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd5 || status !== 4'b0000) begin
            failures++;
            $display("FAIL add_after_reset: out_valid=%b result=%h status=%b, want 1 5 0000", out_valid, result, status);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_cycle();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset_abort();
`else
        test_mul_disabled();
        test_reset_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
